// File: rtl/execute_unit_pkg.sv
// Shared widths, opcode values, FSM encoding and small decode helpers
// for the execute unit and its ALU.
package execute_unit_pkg;

  localparam int DATA_WIDTH = 18;
  localparam int ADDR_WIDTH = 4;
  localparam int CNT_WIDTH  = 5;

  // Shift counts above this are clamped; MUL always takes this many steps.
  localparam logic [CNT_WIDTH-1:0] SHIFT_MAX = 5'd18;
  localparam logic [CNT_WIDTH-1:0] MUL_STEPS = 5'd18;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Opcodes whose completion writes the register file (NOP, CMP, 11-15 do not).
  function automatic logic op_writes(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_NOT, OP_SHL, OP_SHR, OP_MUL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Shift distance taken from operand2[4:0], clamped to the data width.
  function automatic logic [CNT_WIDTH-1:0] sat_count(input logic [CNT_WIDTH-1:0] c);
    if (c > SHIFT_MAX) begin
      return SHIFT_MAX;
    end else begin
      return c;
    end
  endfunction

endpackage

// File: rtl/execute_unit_alu_core.sv
// Combinational single-cycle ALU: arithmetic, logic and compare.
// Shifts and multiply are iterated in execute_unit and yield zero here.
module alu_core
  import execute_unit_pkg::*;
#(
  parameter int DW = execute_unit_pkg::DATA_WIDTH
) (
  input  logic [3:0]    opcode_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] result_o,
  output logic          zero_o,
  output logic          carry_o
);

  logic [DW:0] sum_s;

  // Result and carry for each single-cycle opcode; CMP yields the difference
  always_comb begin
    sum_s    = '0;
    result_o = '0;
    carry_o  = 1'b0;
    case (opcode_i)
      OP_ADD: begin
        sum_s    = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum_s[DW-1:0];
        carry_o  = sum_s[DW];
      end
      OP_SUB, OP_CMP: begin
        result_o = a_i - b_i;
        carry_o  = (a_i < b_i);
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOT:  result_o = ~a_i;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/execute_unit.sv
// Execute unit: latches one request in IDLE, runs it in the ALU (EXEC) or
// bit-serially (ITER, for shifts and multiply), then pulses done for one
// cycle in DONE with a registered result/flags and register-file write.
module execute_unit #(
  parameter int DATA_WIDTH = execute_unit_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = execute_unit_pkg::ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            opcode,
  input  logic [ADDR_WIDTH-1:0] dest_reg,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [ADDR_WIDTH-1:0] write_reg,
  output logic                  write_load,
  output logic                  zero_flag,
  output logic                  carry_flag
);
  import execute_unit_pkg::*;

  localparam int PW = 2 * DATA_WIDTH;

  state_e                state_q, state_d;
  logic [3:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] dest_q, dest_d;
  logic [DATA_WIDTH-1:0] opa_q, opa_d;      // operand1 / shift register
  logic [DATA_WIDTH-1:0] opb_q, opb_d;      // operand2 / multiplier
  logic [PW-1:0]         mcand_q, mcand_d;  // multiplicand, moves left
  logic [PW-1:0]         prod_q, prod_d;    // partial product
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;      // remaining iterations
  logic                  shc_q, shc_d;      // last bit shifted out
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic                  zero_q, zero_d, carry_q, carry_d;
  logic                  done_q, done_d, wload_q, wload_d, busy_q, busy_d;

  logic [DATA_WIDTH-1:0] alu_res_s;
  logic                  alu_zero_s, alu_carry_s;
  logic [PW-1:0]         prod_step_s;
  logic [DATA_WIDTH-1:0] shv_s;
  logic                  shbit_s;
  logic                  fin_s, fin_carry_s;
  logic [DATA_WIDTH-1:0] fin_res_s;

  alu_core #(.DW(DATA_WIDTH)) u_alu (
    .opcode_i (op_q),
    .a_i      (opa_q),
    .b_i      (opb_q),
    .result_o (alu_res_s),
    .zero_o   (alu_zero_s),
    .carry_o  (alu_carry_s)
  );

  // FSM next state, iteration datapath and completion bookkeeping
  always_comb begin
    state_d  = state_q;   op_d    = op_q;    dest_d  = dest_q;
    opa_d    = opa_q;     opb_d   = opb_q;   mcand_d = mcand_q;
    prod_d   = prod_q;    cnt_d   = cnt_q;   shc_d   = shc_q;
    result_d = result_q;  wreg_d  = wreg_q;
    zero_d   = zero_q;    carry_d = carry_q;
    done_d   = 1'b0;      wload_d = 1'b0;
    fin_s    = 1'b0;      fin_res_s = '0;    fin_carry_s = 1'b0;

    prod_step_s = prod_q + (opb_q[0] ? mcand_q : '0);
    if (op_q == OP_SHL) begin
      shv_s   = {opa_q[DATA_WIDTH-2:0], 1'b0};
      shbit_s = opa_q[DATA_WIDTH-1];
    end else begin
      shv_s   = {1'b0, opa_q[DATA_WIDTH-1:1]};
      shbit_s = opa_q[0];
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = opcode;
          dest_d  = dest_reg;
          opa_d   = operand1;
          opb_d   = operand2;
          mcand_d = {{DATA_WIDTH{1'b0}}, operand1};
          prod_d  = '0;
          shc_d   = 1'b0;
          if (opcode == OP_MUL) begin
            cnt_d   = MUL_STEPS;
            state_d = ST_ITER;
          end else if (opcode == OP_SHL || opcode == OP_SHR) begin
            cnt_d   = sat_count(operand2[CNT_WIDTH-1:0]);
            state_d = ST_ITER;
          end else begin
            state_d = ST_EXEC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        fin_s       = 1'b1;
        fin_res_s   = alu_res_s;
        fin_carry_s = alu_carry_s;
      end
      ST_ITER: begin
        if (op_q == OP_MUL) begin
          prod_d  = prod_step_s;
          mcand_d = {mcand_q[PW-2:0], 1'b0};
          opb_d   = {1'b0, opb_q[DATA_WIDTH-1:1]};
          cnt_d   = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            fin_s       = 1'b1;
            fin_res_s   = prod_step_s[DATA_WIDTH-1:0];
            fin_carry_s = |prod_step_s[PW-1:DATA_WIDTH];
          end else begin
            fin_s = 1'b0;
          end
        end else if (cnt_q == 5'd0) begin
          // Zero-distance shift: one idle ITER cycle, operand passes through
          fin_s       = 1'b1;
          fin_res_s   = opa_q;
          fin_carry_s = shc_q;
        end else begin
          opa_d = shv_s;
          shc_d = shbit_s;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            fin_s       = 1'b1;
            fin_res_s   = shv_s;
            fin_carry_s = shbit_s;
          end else begin
            fin_s = 1'b0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (fin_s) begin
      state_d = ST_DONE;
      done_d  = 1'b1;
      wload_d = op_writes(op_q);
      wreg_d  = dest_q;
      if (op_writes(op_q)) begin
        result_d = fin_res_s;
        zero_d   = (fin_res_s == '0);
        carry_d  = fin_carry_s;
      end else if (op_q == OP_CMP) begin
        zero_d  = alu_zero_s;
        carry_d = alu_carry_s;
      end else begin
        result_d = result_q;
      end
    end else begin
      done_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers; reset aborts any operation in progress
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;  op_q    <= OP_NOP;  dest_q  <= '0;
      opa_q    <= '0;       opb_q   <= '0;      mcand_q <= '0;
      prod_q   <= '0;       cnt_q   <= '0;      shc_q   <= 1'b0;
      result_q <= '0;       wreg_q  <= '0;
      zero_q   <= 1'b0;     carry_q <= 1'b0;
      done_q   <= 1'b0;     wload_q <= 1'b0;    busy_q  <= 1'b0;
    end else begin
      state_q  <= state_d;  op_q    <= op_d;    dest_q  <= dest_d;
      opa_q    <= opa_d;    opb_q   <= opb_d;   mcand_q <= mcand_d;
      prod_q   <= prod_d;   cnt_q   <= cnt_d;   shc_q   <= shc_d;
      result_q <= result_d; wreg_q  <= wreg_d;
      zero_q   <= zero_d;   carry_q <= carry_d;
      done_q   <= done_d;   wload_q <= wload_d; busy_q  <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign write_reg  = wreg_q;
  assign write_load = wload_q;
  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;

endmodule

// File: tb/tb_execute_unit.sv
// Scoreboard bench for execute_unit: the driver computes each expected
// completion from an arithmetic reference model and queues it; a monitor
// compares every done pulse and the held outputs between operations.
module tb_execute_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic [3:0]  dest_reg = 4'd0;
  logic [17:0] operand1 = 18'd0;
  logic [17:0] operand2 = 18'd0;
  logic        busy, done, write_load, zero_flag, carry_flag;
  logic [17:0] result;
  logic [3:0]  write_reg;

  execute_unit dut (
    .clock(clock), .reset(reset), .start(start), .opcode(opcode),
    .dest_reg(dest_reg), .operand1(operand1), .operand2(operand2),
    .busy(busy), .done(done), .result(result), .write_reg(write_reg),
    .write_load(write_load), .zero_flag(zero_flag), .carry_flag(carry_flag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [17:0] res;
    logic [3:0]  wreg;
    logic        wl;
    logic        z;
    logic        c;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Architectural state of the reference model and the values the DUT must hold
  logic [17:0] m_res = 18'd0;
  logic        m_z = 1'b0, m_c = 1'b0;
  logic [17:0] h_res = 18'd0;
  logic [3:0]  h_wreg = 4'd0;
  logic        h_z = 1'b0, h_c = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per done pulse, otherwise checks held outputs
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            chk("result",     64'(result),     64'(e.res));
            chk("write_reg",  64'(write_reg),  64'(e.wreg));
            chk("write_load", 64'(write_load), 64'(e.wl));
            chk("zero_flag",  64'(zero_flag),  64'(e.z));
            chk("carry_flag", 64'(carry_flag), 64'(e.c));
            chk("latency",    64'(cyc - e.t0), 64'(e.lat));
            h_res = e.res; h_wreg = e.wreg; h_z = e.z; h_c = e.c;
          end
        end else begin
          chk("load_without_done", 64'(write_load), 64'd0);
          chk("held_outputs", {27'd0, result, write_reg, zero_flag, carry_flag, 13'd0},
                              {27'd0, h_res, h_wreg, h_z, h_c, 13'd0});
        end
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) return;
      @(negedge clock);
    end
    chk("idle_timeout", 64'd1, 64'd0);
  endtask

  // Reference model: expected outcome of one operation from plain arithmetic
  task automatic issue(input logic [3:0] op, input logic [3:0] dst,
                       input logic [17:0] a, input logic [17:0] b);
    exp_t e;
    longint unsigned av, bv, p, r, mask;
    int n;
    bit upd_res, upd_flag, c;
    wait_idle();
    mask = 64'h3FFFF; av = a; bv = b;
    upd_res = 0; upd_flag = 0; c = 0; r = 0; e.lat = 2;
    n = int'(b[4:0]);
    if (n > 18) n = 18;
    case (op)
      4'd1: begin p = av + bv; r = p & mask; c = (p > mask); upd_res = 1; end
      4'd2: begin r = (av - bv) & mask; c = (av < bv); upd_res = 1; end
      4'd3: begin r = av & bv; upd_res = 1; end
      4'd4: begin r = av | bv; upd_res = 1; end
      4'd5: begin r = av ^ bv; upd_res = 1; end
      4'd6: begin r = (~av) & mask; upd_res = 1; end
      4'd7: begin
        r = (av << n) & mask;
        c = (n == 0) ? 1'b0 : 1'(av >> (18 - n));
        e.lat = 1 + ((n == 0) ? 1 : n); upd_res = 1;
      end
      4'd8: begin
        r = av >> n;
        c = (n == 0) ? 1'b0 : 1'(av >> (n - 1));
        e.lat = 1 + ((n == 0) ? 1 : n); upd_res = 1;
      end
      4'd9: begin p = av * bv; r = p & mask; c = ((p >> 18) != 0); e.lat = 19; upd_res = 1; end
      4'd10: begin r = (av - bv) & mask; c = (av < bv); upd_flag = 1; end
      default: begin upd_res = 0; end
    endcase
    if (upd_res || upd_flag) begin m_z = (r == 0); m_c = c; end
    if (upd_res) m_res = 18'(r);
    e.res = m_res; e.z = m_z; e.c = m_c; e.wl = upd_res; e.wreg = dst; e.t0 = cyc;
    sb.push_back(e);
    start = 1'b1; opcode = op; dest_reg = dst; operand1 = a; operand2 = b;
    @(negedge clock);
    start = 1'b0;
    opcode = 4'($urandom); dest_reg = 4'($urandom);
    operand1 = 18'($urandom); operand2 = 18'($urandom);
  endtask

  task automatic chk_zero_outputs(input string name);
    chk(name, {busy, done, write_load, zero_flag, carry_flag, result, write_reg},
              64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk_zero_outputs("reset_values");
    reset = 1'b0;
    @(negedge clock);

    issue(4'd1, 4'd5, 18'h3FFFF, 18'h00001);   // wrap to zero with carry
    issue(4'd2, 4'd1, 18'd3, 18'd5);           // borrow
    issue(4'd10, 4'd2, 18'd7, 18'd7);          // compare equal, result held
    issue(4'd7, 4'd3, 18'h00003, 18'd4);       // shift left by 4
    issue(4'd8, 4'd4, 18'h2ABCD, 18'd25);      // saturated right shift
    issue(4'd7, 4'd6, 18'h12345, 18'd0);       // zero-distance shift
    issue(4'd8, 4'd7, 18'h20001, 18'd18);      // full-width shift out
    issue(4'd9, 4'd7, 18'd300, 18'd500);       // 150000
    issue(4'd9, 4'd8, 18'h3FFFF, 18'd2);       // high product bit
    issue(4'd0, 4'd9, 18'h11111, 18'h22222);   // NOP
    issue(4'd13, 4'd10, 18'h1, 18'h1);         // undefined opcode
    issue(4'd3, 4'd11, 18'h3C3C3, 18'h0FF0F);
    issue(4'd4, 4'd12, 18'h30000, 18'h00003);
    issue(4'd5, 4'd13, 18'h3FFFF, 18'h3FFFF);
    issue(4'd6, 4'd14, 18'h3FFFF, 18'h0);

    // A start pulse while a multiply is running must be ignored
    issue(4'd9, 4'd15, 18'd1234, 18'd77);
    repeat (3) @(negedge clock);
    start = 1'b1; opcode = 4'd1; dest_reg = 4'd2;
    @(negedge clock);
    start = 1'b0;

    // Asynchronous reset in the middle of a multiply
    issue(4'd9, 4'd3, 18'd999, 18'd999);
    repeat (6) @(negedge clock);
    #2;
    reset = 1'b1;
    sb.delete();
    m_res = 18'd0; m_z = 1'b0; m_c = 1'b0;
    h_res = 18'd0; h_wreg = 4'd0; h_z = 1'b0; h_c = 1'b0;
    #1;
    chk_zero_outputs("reset_mid_mul");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    for (int k = 0; k < 150; k++) begin
      issue(4'($urandom_range(0, 15)), 4'($urandom), 18'($urandom), 18'($urandom));
    end

    wait_idle();
    repeat (3) @(negedge clock);
    chk("queue_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
